// File: rtl/programa_tp2.sv
// Single-digit UART calculator: 8N1 receiver, command FSM with ALU, 8N1 transmitter.
// Receives "<digit><op><digit><CR>", shows the result on LEDS and echoes it as one raw byte.
module programa_tp2 #(
    parameter int unsigned BAUD_DIV   = 163,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX,
    output logic       TX,
    output logic [7:0] LEDS,
    output logic [7:0] STATE
);
    localparam int unsigned BW  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned OSW = $clog2(OVERSAMPLE);
    localparam logic [BW-1:0]  BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [OSW-1:0] OS_LAST   = OSW'(OVERSAMPLE - 1);
    localparam logic [OSW-1:0] OS_MID    = OSW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [7:0] {
        WAIT_A  = 8'h01, WAIT_OP = 8'h02, WAIT_B  = 8'h04, WAIT_EQ = 8'h08,
        COMPUTE = 8'h10, SEND    = 8'h20, WAIT_TX = 8'h40
    } cmd_state_t;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR} op_t;

    logic [BW-1:0] baud_cnt;
    logic          tick;

    always_ff @(posedge CLK or negedge RESET)
        if (!RESET)    baud_cnt <= '0;
        else if (tick) baud_cnt <= '0;
        else           baud_cnt <= baud_cnt + 1'b1;

    assign tick = (baud_cnt == BAUD_LAST);

    logic rx_meta, rx_s;

    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_s    <= rx_meta;
        end

    rx_state_t      rx_state, rx_state_n;
    logic [OSW-1:0] rx_tcnt, rx_tcnt_n;
    logic [2:0]     rx_bcnt, rx_bcnt_n;
    logic [7:0]     rx_data, rx_data_n;
    logic           rx_done, rx_done_n;

    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_bcnt  <= '0;
            rx_data  <= '0;
            rx_done  <= 1'b0;
        end else begin
            rx_state <= rx_state_n;
            rx_tcnt  <= rx_tcnt_n;
            rx_bcnt  <= rx_bcnt_n;
            rx_data  <= rx_data_n;
            rx_done  <= rx_done_n;
        end

    // Stop-bit decision is taken at mid-stop so a back-to-back start edge is not missed.
    always_comb begin
        rx_state_n = rx_state;
        rx_tcnt_n  = rx_tcnt;
        rx_bcnt_n  = rx_bcnt;
        rx_data_n  = rx_data;
        rx_done_n  = 1'b0;
        case (rx_state)
            RX_IDLE:
                if (!rx_s) begin
                    rx_state_n = RX_START;
                    rx_tcnt_n  = '0;
                end
            RX_START:
                if (tick) begin
                    if (rx_tcnt == OS_MID) begin
                        rx_tcnt_n  = '0;
                        rx_bcnt_n  = '0;
                        rx_state_n = rx_s ? RX_IDLE : RX_DATA;
                    end else rx_tcnt_n = rx_tcnt + 1'b1;
                end
            RX_DATA:
                if (tick) begin
                    if (rx_tcnt == OS_LAST) begin
                        rx_tcnt_n = '0;
                        rx_data_n = {rx_s, rx_data[7:1]};
                        if (rx_bcnt == 3'd7) rx_state_n = RX_STOP;
                        else                 rx_bcnt_n  = rx_bcnt + 1'b1;
                    end else rx_tcnt_n = rx_tcnt + 1'b1;
                end
            RX_STOP:
                if (tick) begin
                    if (rx_tcnt == OS_LAST) begin
                        rx_done_n  = rx_s;
                        rx_state_n = RX_IDLE;
                    end else rx_tcnt_n = rx_tcnt + 1'b1;
                end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    tx_state_t      tx_state, tx_state_n;
    logic [OSW-1:0] tx_tcnt, tx_tcnt_n;
    logic [2:0]     tx_bcnt, tx_bcnt_n;
    logic [7:0]     tx_shift, tx_shift_n;
    logic           tx_done, tx_done_n;
    logic           tx_start;

    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_bcnt  <= '0;
            tx_shift <= '0;
            tx_done  <= 1'b0;
        end else begin
            tx_state <= tx_state_n;
            tx_tcnt  <= tx_tcnt_n;
            tx_bcnt  <= tx_bcnt_n;
            tx_shift <= tx_shift_n;
            tx_done  <= tx_done_n;
        end

    always_comb begin
        tx_state_n = tx_state;
        tx_tcnt_n  = tx_tcnt;
        tx_bcnt_n  = tx_bcnt;
        tx_shift_n = tx_shift;
        tx_done_n  = 1'b0;
        case (tx_state)
            TX_IDLE:
                if (tx_start) begin
                    tx_shift_n = LEDS;
                    tx_tcnt_n  = '0;
                    tx_state_n = TX_START;
                end
            TX_START:
                if (tick) begin
                    if (tx_tcnt == OS_LAST) begin
                        tx_tcnt_n  = '0;
                        tx_bcnt_n  = '0;
                        tx_state_n = TX_DATA;
                    end else tx_tcnt_n = tx_tcnt + 1'b1;
                end
            TX_DATA:
                if (tick) begin
                    if (tx_tcnt == OS_LAST) begin
                        tx_tcnt_n  = '0;
                        tx_shift_n = {1'b0, tx_shift[7:1]};
                        if (tx_bcnt == 3'd7) tx_state_n = TX_STOP;
                        else                 tx_bcnt_n  = tx_bcnt + 1'b1;
                    end else tx_tcnt_n = tx_tcnt + 1'b1;
                end
            TX_STOP:
                if (tick) begin
                    if (tx_tcnt == OS_LAST) begin
                        tx_done_n  = 1'b1;
                        tx_state_n = TX_IDLE;
                    end else tx_tcnt_n = tx_tcnt + 1'b1;
                end
            default: tx_state_n = TX_IDLE;
        endcase
    end

    always_comb begin
        TX = 1'b1;
        if (tx_state == TX_START)     TX = 1'b0;
        else if (tx_state == TX_DATA) TX = tx_shift[0];
    end

    cmd_state_t state, state_n;
    logic [3:0] a, a_n, b, b_n;
    op_t        op, op_n, op_dec;
    logic [7:0] leds, leds_n, result;
    logic       is_digit, is_op;

    always_ff @(posedge CLK or negedge RESET)
        if (!RESET) begin
            state <= WAIT_A;
            a     <= '0;
            b     <= '0;
            op    <= OP_ADD;
            leds  <= '0;
        end else begin
            state <= state_n;
            a     <= a_n;
            b     <= b_n;
            op    <= op_n;
            leds  <= leds_n;
        end

    // ASCII digits 0x30..0x39 carry their value in the low nibble.
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);

    always_comb begin
        is_op  = 1'b1;
        op_dec = OP_ADD;
        case (rx_data)
            8'h2B:   op_dec = OP_ADD;
            8'h2D:   op_dec = OP_SUB;
            8'h26:   op_dec = OP_AND;
            8'h7C:   op_dec = OP_OR;
            8'h5E:   op_dec = OP_XOR;
            default: is_op  = 1'b0;
        endcase
    end

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:  result = {4'h0, a} + {4'h0, b};
            OP_SUB:  result = {4'h0, a} - {4'h0, b};
            OP_AND:  result = {4'h0, a & b};
            OP_OR:   result = {4'h0, a | b};
            OP_XOR:  result = {4'h0, a ^ b};
            default: result = '0;
        endcase
    end

    always_comb begin
        state_n  = state;
        a_n      = a;
        b_n      = b;
        op_n     = op;
        leds_n   = leds;
        tx_start = 1'b0;
        case (state)
            WAIT_A:
                if (rx_done) begin
                    state_n = is_digit ? WAIT_OP : WAIT_A;
                    if (is_digit) a_n = rx_data[3:0];
                end
            WAIT_OP:
                if (rx_done) begin
                    state_n = is_op ? WAIT_B : WAIT_A;
                    if (is_op) op_n = op_dec;
                end
            WAIT_B:
                if (rx_done) begin
                    state_n = is_digit ? WAIT_EQ : WAIT_A;
                    if (is_digit) b_n = rx_data[3:0];
                end
            WAIT_EQ:
                if (rx_done) state_n = (rx_data == 8'h0D) ? COMPUTE : WAIT_A;
            COMPUTE: begin
                leds_n  = result;
                state_n = SEND;
            end
            SEND: begin
                tx_start = 1'b1;
                state_n  = WAIT_TX;
            end
            WAIT_TX:
                if (tx_done) state_n = WAIT_A;
            default: state_n = WAIT_A;
        endcase
    end

    assign LEDS  = leds;
    assign STATE = state;

endmodule

// File: tb/tb_programa_tp2.sv
// Directed bench for the UART calculator: drives 8N1 frames on RX, decodes TX,
// and checks LEDS every cycle against a command-level calculator model.
module tb_programa_tp2;
    localparam int unsigned BAUD_DIV = 4;
    localparam int unsigned OS       = 16;
    localparam int          BIT      = BAUD_DIV * OS;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       RX = 1'b1;
    logic       TX;
    logic [7:0] LEDS, STATE;

    programa_tp2 #(.BAUD_DIV(BAUD_DIV), .OVERSAMPLE(OS)) dut (
        .CLK(CLK), .RESET(RESET), .RX(RX), .TX(TX), .LEDS(LEDS), .STATE(STATE)
    );

    always #2 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Calculator model: parses the byte stream the bench sends.
    logic [7:0] exp_leds = 8'h00;
    int         pstate = 0;
    logic [7:0] pa, pop, pb;
    logic [7:0] exp_tx_q[$];
    logic [7:0] got_tx_q[$];
    bit         window = 1'b1;
    bit         mon_en = 1'b1;
    bit         rec = 1'b0;
    logic [7:0] st_q[$];

    function automatic bit digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic bit opchar(input logic [7:0] c);
        return (c == 8'h2B) || (c == 8'h2D) || (c == 8'h26) || (c == 8'h7C) || (c == 8'h5E);
    endfunction

    function automatic logic [7:0] calc(input logic [7:0] x, input logic [7:0] o, input logic [7:0] y);
        case (o)
            8'h2B:   return x + y;
            8'h2D:   return x - y;
            8'h26:   return x & y;
            8'h7C:   return x | y;
            default: return x ^ y;
        endcase
    endfunction

    task automatic model_byte(input logic [7:0] c);
        case (pstate)
            0: if (digit(c)) begin pa = c - 8'h30; pstate = 1; end else pstate = 0;
            1: if (opchar(c)) begin pop = c; pstate = 2; end else pstate = 0;
            2: if (digit(c)) begin pb = c - 8'h30; pstate = 3; end else pstate = 0;
            default: begin
                if (c == 8'h0D) begin
                    exp_leds = calc(pa, pop, pb);
                    exp_tx_q.push_back(exp_leds);
                end
                pstate = 0;
            end
        endcase
    endtask

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // LEDS is only allowed to change while a stop bit is on the line or around reset.
    always @(posedge CLK) begin
        #1;
        if (!window) begin
            checks++;
            if (LEDS !== exp_leds) begin
                errors++;
                $display("FAIL leds_model: got %02h expected %02h at %0t", LEDS, exp_leds, $time);
            end
        end
    end

    always @(negedge CLK)
        if (rec && (st_q.size() == 0 || STATE != st_q[$])) st_q.push_back(STATE);

    initial begin : tx_monitor
        logic [7:0] v;
        logic       stop;
        forever begin
            @(posedge CLK);
            if (RESET && TX === 1'b0) begin
                repeat (BIT / 2) @(posedge CLK);
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT) @(posedge CLK);
                    v[i] = TX;
                end
                repeat (BIT) @(posedge CLK);
                stop = TX;
                if (mon_en) begin
                    checks++;
                    if (stop !== 1'b1) begin
                        errors++;
                        $display("FAIL tx_stop_bit: got %b expected 1", stop);
                    end
                    got_tx_q.push_back(v);
                end
            end
        end
    end

    task automatic send_byte(input logic [7:0] c, input bit good_stop);
        RX = 1'b0;
        repeat (BIT) @(negedge CLK);
        for (int i = 0; i < 8; i++) begin
            RX = c[i];
            repeat (BIT) @(negedge CLK);
        end
        if (good_stop) model_byte(c);
        window = 1'b1;
        RX = good_stop;
        repeat (BIT) @(negedge CLK);
        RX = 1'b1;
        window = 1'b0;
    endtask

    task automatic expect_tx(input string name, input logic [7:0] lit);
        int n;
        logic [7:0] got, mexp;
        n = 0;
        while (got_tx_q.size() == 0 && n < 40 * BIT) begin
            @(negedge CLK);
            n++;
        end
        if (got_tx_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: no TX byte within %0d cycles, expected %02h", name, 40 * BIT, lit);
        end else begin
            got = got_tx_q.pop_front();
            mexp = (exp_tx_q.size() != 0) ? exp_tx_q.pop_front() : 8'hxx;
            check8({name, "_model"}, got, mexp);
            check8({name, "_literal"}, got, lit);
        end
        repeat (BIT) @(negedge CLK);
    endtask

    task automatic run_cmd(input string name, input logic [7:0] c0, input logic [7:0] c1,
                           input logic [7:0] c2, input logic [7:0] c3, input logic [7:0] lit);
        send_byte(c0, 1'b1);
        send_byte(c1, 1'b1);
        send_byte(c2, 1'b1);
        send_byte(c3, 1'b1);
        expect_tx({name, "_tx"}, lit);
        check8({name, "_leds"}, LEDS, lit);
        check8({name, "_state_idle"}, STATE, 8'h01);
    endtask

    initial begin
        logic [7:0] walk [8];
        int n;
        walk = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h01};

        repeat (5) @(negedge CLK);
        RESET = 1'b1;
        @(negedge CLK);
        check8("reset_tx", {7'd0, TX}, 8'h01);
        check8("reset_leds", LEDS, 8'h00);
        check8("reset_state", STATE, 8'h01);
        window = 1'b0;
        repeat (2 * BIT) @(negedge CLK);

        // "2-1\r" with an idle gap after the first byte, STATE walk recorded.
        rec = 1'b1;
        send_byte(8'h32, 1'b1);
        repeat (3 * BIT) @(negedge CLK);
        send_byte(8'h2D, 1'b1);
        send_byte(8'h31, 1'b1);
        send_byte(8'h0D, 1'b1);
        expect_tx("sub_2_1_tx", 8'h01);
        rec = 1'b0;
        check8("sub_2_1_leds", LEDS, 8'h01);
        check_int("state_walk_len", st_q.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < st_q.size()) check8("state_walk", st_q[i], walk[i]);

        run_cmd("add_2_2", 8'h32, 8'h2B, 8'h32, 8'h0D, 8'h04);
        run_cmd("sub_1_2", 8'h31, 8'h2D, 8'h32, 8'h0D, 8'hFF);

        // Unexpected byte aborts the command.
        send_byte(8'h32, 1'b1);
        send_byte(8'h78, 1'b1);
        repeat (2) @(negedge CLK);
        check8("bad_op_state", STATE, 8'h01);
        repeat (20 * BIT) @(negedge CLK);
        check_int("bad_op_no_tx", got_tx_q.size(), 0);
        check8("bad_op_leds", LEDS, 8'hFF);

        // Framing error: '2' with a zero stop bit is dropped.
        send_byte(8'h32, 1'b0);
        check8("framing_state", STATE, 8'h01);
        repeat (20 * BIT) @(negedge CLK);
        check8("framing_state_late", STATE, 8'h01);

        // One-tick glitch must not start a byte; the following command decodes cleanly.
        RX = 1'b0;
        repeat (BAUD_DIV) @(negedge CLK);
        RX = 1'b1;
        repeat (3 * BIT) @(negedge CLK);
        check8("glitch_state", STATE, 8'h01);
        run_cmd("xor_7_5", 8'h37, 8'h5E, 8'h35, 8'h0D, 8'h02);
        check_int("no_extra_tx", got_tx_q.size(), 0);

        // Reset in the middle of the response frame.
        send_byte(8'h33, 1'b1);
        send_byte(8'h7C, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h0D, 1'b1);
        check8("or_3_4_leds", LEDS, 8'h07);
        n = 0;
        while (TX !== 1'b0 && n < 20 * BIT) begin
            @(negedge CLK);
            n++;
        end
        check_int("tx_started_before_reset", n < 20 * BIT ? 1 : 0, 1);
        repeat (3 * BIT) @(negedge CLK);
        window = 1'b1;
        mon_en = 1'b0;
        #1;
        RESET = 1'b0;
        #1;
        check8("midtx_reset_tx", {7'd0, TX}, 8'h01);
        check8("midtx_reset_state", STATE, 8'h01);
        check8("midtx_reset_leds", LEDS, 8'h00);
        exp_leds = 8'h00;
        pstate = 0;
        exp_tx_q.delete();
        repeat (4) @(negedge CLK);
        RESET = 1'b1;
        repeat (2) @(negedge CLK);
        window = 1'b0;
        repeat (4 * BIT) @(negedge CLK);
        check8("after_reset_state", STATE, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
